chart_sequencer: RTL and testbench
==================================

// Module: chart_sequencer
// PURPOSE
//   Upstream note-chart source for the falling-note lane logic. Presents the next 4-bit note
//   pattern (bit0 red .. bit3 yellow) on command_out and advances one chart entry per
//   request pulse (the lane's trocar). Tracks the chart position, end-of-chart and a count
//   of delivered patterns for the HUD and score logic.
// PARAMETERS
//   CHART_LEN  16       number of chart entries used, 1..16 (entries 0..CHART_LEN-1 of table)
//   LOOP       1        1: wrap to entry 0 after the last entry; 0: stop in DONE
//   LFSR_SEED  16'hACE1 initial LFSR state, used only with RANDOM_CHART_EN
// PORTS
//   CLOCK_25       in   1  25 MHz system clock
//   reset          in   1  synchronous, active-high reset
//   start          in   1  1-cycle pulse: (re)start the chart from entry 0
//   req            in   1  next-pattern request (lane trocar); level input, rising edge used
//   command_out    out  4  current pattern for the lane's command_in
//   valid          out  1  1 while in PLAY
//   done           out  1  1 while in DONE
//   chart_idx      out  4  index of the entry currently on command_out
//   patterns_sent  out  8  number of consumed patterns since start, saturates at 255
// BEHAVIOUR
//   - Reset: state IDLE, command_out=0, valid=0, done=0, chart_idx=0, patterns_sent=0,
//     req edge-detect register=0 (LFSR loaded with LFSR_SEED).
//   - Chart table (fixed, entry0..15): 1,2,4,8,3,0,5,A,C,6,9,F,8,4,2,1 (hex). 0 = rest.
//   - Edge detect: req_q <= req every cycle; req_rise = req & ~req_q.
//   - FSM:
//     IDLE: command_out=0. start -> PLAY, chart_idx=0, command_out=table[0], valid=1.
//           req_rise ignored.
//     PLAY: on req_rise: patterns_sent+=1 (sat 255); if chart_idx==CHART_LEN-1:
//           LOOP=1 -> chart_idx=0, command_out=table[0]; LOOP=0 -> DONE, command_out=0,
//           valid=0, done=1. Else chart_idx+=1, command_out=table[chart_idx+1].
//     DONE: hold outputs; start -> PLAY as from IDLE (done=0). req_rise ignored.
//   - Latency: command_out/chart_idx update on the clock edge after the cycle in which
//     req_rise is high. A consumer sampling command_in on that same edge (trocar=1) gets
//     the pre-advance pattern; the new pattern is therefore pre-presented for the next
//     request. Held-high req advances exactly once.
//   - start and req_rise in same cycle: start wins; patterns_sent cleared to 0, entry 0.
//   - start in PLAY: restart at entry 0, patterns_sent=0.
//   - reset mid-PLAY: all outputs return to reset values on the next edge.
//   - CHART_LEN=1, LOOP=1: command_out stays table[0], patterns_sent still counts.
// CONFIGURATION
//   RANDOM_CHART_EN defined: patterns come from a 16-bit Galois LFSR (mask 16'hB400,
//     shift right, lsb feedback), stepped once per start and per req_rise in PLAY;
//     command_out = new lfsr[3:0]. LFSR_SEED==0 is replaced by 16'h0001. start reloads seed
//     before stepping. chart_idx counts mod CHART_LEN; LOOP ignored, DONE never entered.
//   RANDOM_CHART_EN undefined: table-driven as above; no LFSR logic synthesised.
// TESTING
//   1. reset, then start pulse -> next edge valid=1, command_out=4'h1, chart_idx=0.
//   2. PLAY, req high 1 cycle -> one edge later command_out=4'h2, chart_idx=1, sent=1;
//      req held 10 cycles -> single advance only.
//   3. LOOP=0, CHART_LEN=4, 4 req pulses -> command_out 2,4,8 then DONE: done=1,
//      valid=0, command_out=0, sent=4; further req -> no change; start -> command_out=1.
//   4. LOOP=1, CHART_LEN=16, 16 req pulses -> chart_idx wraps 15->0, command_out=1,
//      sent=16; 300 pulses total -> sent=255.
//   5. start and req_rise same cycle in PLAY at idx 5 -> chart_idx=0, command_out=1, sent=0;
//      reset asserted mid-PLAY -> IDLE, all outputs 0.
//   6. RANDOM_CHART_EN, LFSR_SEED=16'hACE1: start -> command_out matches reference LFSR
//      model step 1; 100 reqs match model sequence; done stays 0.

Source files
------------

// File: rtl/chart_sequencer_if.sv
// Handshake bundle between the chart sequencer and its consumer (the falling-note lane).
// The lane drives start/req and receives the presented pattern plus HUD status.
interface chart_sequencer_if;
    logic       start;
    logic       req;
    logic [3:0] command_out;
    logic       valid;
    logic       done;
    logic [3:0] chart_idx;
    logic [7:0] patterns_sent;

    modport master (
        output start, req,
        input  command_out, valid, done, chart_idx, patterns_sent
    );

    modport slave (
        input  start, req,
        output command_out, valid, done, chart_idx, patterns_sent
    );
endinterface

// File: rtl/chart_sequencer.sv
// Note-chart source: presents the next 4-bit pattern and advances once per req rising edge.
// Optional feature macro RANDOM_CHART_EN swaps the fixed table for a 16-bit Galois LFSR.
module chart_sequencer #(
    parameter int          CHART_LEN = 16,
    parameter bit          LOOP      = 1'b1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              CLOCK_25,
    input  logic              reset,
    chart_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    localparam logic [3:0]  LAST_IDX = 4'(CHART_LEN - 1);
    localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    state_t     state_q, state_d;
    logic [3:0] cmd_q, cmd_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] sent_q, sent_d;
    logic       valid_q, valid_d;
    logic       done_q, done_d;
    logic       req_q, req_d;
    logic       req_rise;
    logic [7:0] sent_inc;

    assign req_rise = bus.req & ~req_q;
    assign sent_inc = (sent_q == 8'hFF) ? sent_q : sent_q + 8'd1;

`ifdef RANDOM_CHART_EN
    logic [15:0] lfsr_q, lfsr_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction
`else
    function automatic logic [3:0] chart_entry(input logic [3:0] i);
        logic [3:0] e;
        case (i)
            4'd0:    e = 4'h1;
            4'd1:    e = 4'h2;
            4'd2:    e = 4'h4;
            4'd3:    e = 4'h8;
            4'd4:    e = 4'h3;
            4'd5:    e = 4'h0;
            4'd6:    e = 4'h5;
            4'd7:    e = 4'hA;
            4'd8:    e = 4'hC;
            4'd9:    e = 4'h6;
            4'd10:   e = 4'h9;
            4'd11:   e = 4'hF;
            4'd12:   e = 4'h8;
            4'd13:   e = 4'h4;
            4'd14:   e = 4'h2;
            default: e = 4'h1;
        endcase
        return e;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        sent_d  = sent_q;
        valid_d = valid_q;
        done_d  = done_q;
        req_d   = bus.req;
`ifdef RANDOM_CHART_EN
        lfsr_d  = lfsr_q;
`endif
        // start beats a simultaneous request and is honoured in every state
        if (bus.start) begin
            state_d = PLAY;
            idx_d   = 4'd0;
            sent_d  = 8'd0;
            valid_d = 1'b1;
            done_d  = 1'b0;
`ifdef RANDOM_CHART_EN
            lfsr_d  = lfsr_step(SEED);
            cmd_d   = lfsr_d[3:0];
`else
            cmd_d   = chart_entry(4'd0);
`endif
        end else if (state_q == PLAY && req_rise) begin
            sent_d = sent_inc;
`ifdef RANDOM_CHART_EN
            lfsr_d = lfsr_step(lfsr_q);
            cmd_d  = lfsr_d[3:0];
            idx_d  = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
`else
            if (idx_q == LAST_IDX) begin
                if (LOOP) begin
                    idx_d = 4'd0;
                    cmd_d = chart_entry(4'd0);
                end else begin
                    state_d = DONE;
                    cmd_d   = 4'd0;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
            end else begin
                idx_d = idx_q + 4'd1;
                cmd_d = chart_entry(idx_q + 4'd1);
            end
`endif
        end
    end

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            state_q <= IDLE;
            cmd_q   <= 4'd0;
            idx_q   <= 4'd0;
            sent_q  <= 8'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
`ifdef RANDOM_CHART_EN
            lfsr_q  <= SEED;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            sent_q  <= sent_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            req_q   <= req_d;
`ifdef RANDOM_CHART_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign bus.command_out   = cmd_q;
    assign bus.valid         = valid_q;
    assign bus.done          = done_q;
    assign bus.chart_idx     = idx_q;
    assign bus.patterns_sent = sent_q;
endmodule

// File: tb/tb_chart_sequencer.sv
// Bench for chart_sequencer: two builds (16-entry looping, 4-entry one-shot) share stimulus
// and are compared every cycle against a rule-level reference model.
module tb_chart_sequencer;
    logic CLOCK_25 = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic req   = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #20 CLOCK_25 = ~CLOCK_25;

    chart_sequencer_if bus0 ();
    chart_sequencer_if bus1 ();
    assign bus0.start = start;
    assign bus0.req   = req;
    assign bus1.start = start;
    assign bus1.req   = req;

    chart_sequencer #(.CHART_LEN(16), .LOOP(1'b1), .LFSR_SEED(16'hACE1)) u_loop (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .bus      (bus0.slave)
    );

    chart_sequencer #(.CHART_LEN(4), .LOOP(1'b0), .LFSR_SEED(16'hACE1)) u_once (
        .CLOCK_25 (CLOCK_25),
        .reset    (reset),
        .bus      (bus1.slave)
    );

    // reference model: mode 0 idle, 1 playing, 2 finished
    logic [3:0]  tbl [16] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h0, 4'h5, 4'hA,
                              4'hC, 4'h6, 4'h9, 4'hF, 4'h8, 4'h4, 4'h2, 4'h1};
    int          m_len  [2] = '{16, 4};
    bit          m_loop [2] = '{1'b1, 1'b0};
    int          m_mode [2];
    int          m_idx  [2];
    int          m_sent [2];
    logic [15:0] m_lfsr [2];
    bit          m_prev_req;

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic [15:0] n;
        n = s / 2;
        if (s % 2 == 1) n = n ^ 16'hB400;
        return n;
    endfunction

    task automatic model(input bit s, input bit r, input bit rst);
        bit rise;
        if (rst) begin
            m_prev_req = 1'b0;
            for (int d = 0; d < 2; d++) begin
                m_mode[d] = 0; m_idx[d] = 0; m_sent[d] = 0; m_lfsr[d] = 16'hACE1;
            end
            return;
        end
        rise = r && !m_prev_req;
        m_prev_req = r;
        for (int d = 0; d < 2; d++) begin
            if (s) begin
                m_mode[d] = 1; m_idx[d] = 0; m_sent[d] = 0;
                m_lfsr[d] = ref_lfsr(16'hACE1);
            end else if (m_mode[d] == 1 && rise) begin
                if (m_sent[d] < 255) m_sent[d]++;
                m_lfsr[d] = ref_lfsr(m_lfsr[d]);
`ifdef RANDOM_CHART_EN
                m_idx[d] = (m_idx[d] + 1) % m_len[d];
`else
                if (m_idx[d] + 1 < m_len[d]) m_idx[d]++;
                else if (m_loop[d]) m_idx[d] = 0;
                else m_mode[d] = 2;
`endif
            end
        end
    endtask

    function automatic logic [3:0] exp_cmd(input int d);
        if (m_mode[d] != 1) return 4'h0;
`ifdef RANDOM_CHART_EN
        return m_lfsr[d][3:0];
`else
        return tbl[m_idx[d]];
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("loop.cmd",   {4'h0, bus0.command_out},   {4'h0, exp_cmd(0)});
        chk("loop.valid", {7'h0, bus0.valid},         {7'h0, m_mode[0] == 1});
        chk("loop.done",  {7'h0, bus0.done},          {7'h0, m_mode[0] == 2});
        chk("loop.idx",   {4'h0, bus0.chart_idx},     8'(m_idx[0]));
        chk("loop.sent",  bus0.patterns_sent,         8'(m_sent[0]));
        chk("once.cmd",   {4'h0, bus1.command_out},   {4'h0, exp_cmd(1)});
        chk("once.valid", {7'h0, bus1.valid},         {7'h0, m_mode[1] == 1});
        chk("once.done",  {7'h0, bus1.done},          {7'h0, m_mode[1] == 2});
        chk("once.idx",   {4'h0, bus1.chart_idx},     8'(m_idx[1]));
        chk("once.sent",  bus1.patterns_sent,         8'(m_sent[1]));
    endtask

    task automatic cycle(input bit s, input bit r, input bit rst = 1'b0);
        @(negedge CLOCK_25);
        start = s; req = r; reset = rst;
        @(posedge CLOCK_25);
        model(s, r, rst);
        #1;
        check_all();
    endtask

    task automatic pulse();
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
    endtask

    initial begin
        // reset state
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);

        // first start presents entry 0
        cycle(1'b1, 1'b0);
`ifndef RANDOM_CHART_EN
        chk("t1.cmd_is_1", {4'h0, bus0.command_out}, 8'h01);
`endif
        // single request pulse, then a long held request advances once
        pulse();
`ifndef RANDOM_CHART_EN
        chk("t2.cmd_is_2", {4'h0, bus0.command_out}, 8'h02);
        chk("t2.idx_is_1", {4'h0, bus0.chart_idx}, 8'h01);
`endif
        repeat (10) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("t2.held_once", bus0.patterns_sent, 8'd2);

        // one-shot build runs off its end; further requests are ignored
        cycle(1'b1, 1'b0);
        repeat (4) pulse();
`ifndef RANDOM_CHART_EN
        chk("t3.done",   {7'h0, bus1.done}, 8'h01);
        chk("t3.sent_4", bus1.patterns_sent, 8'd4);
`endif
        repeat (3) pulse();
        cycle(1'b1, 1'b0);

        // full lap wraps, then saturation of the delivered count
        repeat (16) pulse();
`ifndef RANDOM_CHART_EN
        chk("t4.wrap_idx", {4'h0, bus0.chart_idx}, 8'h00);
        chk("t4.sent_16",  bus0.patterns_sent, 8'd16);
`endif
        repeat (284) pulse();
        chk("t4.sent_sat", bus0.patterns_sent, 8'd255);

        // start and request rising together at idx 5
        cycle(1'b1, 1'b0);
        repeat (5) pulse();
        cycle(1'b1, 1'b1);
        chk("t5.restart_sent", bus0.patterns_sent, 8'd0);
        cycle(1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            cycle(($urandom_range(99) < 3), $urandom_range(1));

        // reset mid-play
        cycle(1'b1, 1'b0);
        pulse();
        cycle(1'b0, 1'b1, 1'b1);
        chk("t5.reset_valid", {7'h0, bus0.valid}, 8'h00);
        cycle(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
